// File: rtl/stride_read_engine.sv
// stride_read_engine: multi-channel strided read request generator feeding one shared FWFT request FIFO; `define STRIDE_READ_ENGINE_ABORT_EN adds cfg_abort
module stride_read_engine #(
  parameter int ENGINE_ID     = 0,
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int ADDR_WIDTH    = 64,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                                  ap_clk,
  input  logic                                  areset,
  input  logic [NUM_CHANNELS-1:0]               cfg_valid,
  output logic [NUM_CHANNELS-1:0]               cfg_ready,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]    cfg_base_address,
  input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] cfg_start,
  input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] cfg_end,
  input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] cfg_stride,
  input  logic [NUM_CHANNELS-1:0]               cfg_decrement,
`ifdef STRIDE_READ_ENGINE_ABORT_EN
  input  logic [NUM_CHANNELS-1:0]               cfg_abort,
`endif
  output logic                                  req_valid,
  input  logic                                  req_ready,
  output logic [7:0]                            req_cu_id,
  output logic [2:0]                            req_channel,
  output logic [ADDR_WIDTH-1:0]                 req_base_address,
  output logic [COUNTER_WIDTH-1:0]              req_address_offset,
  output logic                                  req_last,
  output logic [NUM_CHANNELS-1:0]               chan_done,
  output logic                                  busy
);
  localparam int NC = NUM_CHANNELS;
  localparam int CW = COUNTER_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {S_RESET, S_IDLE, S_SETUP, S_BUSY, S_PAUSE, S_DONE} state_t;
  typedef struct packed {
    logic [2:0]    ch;
    logic [AW-1:0] base;
    logic [CW-1:0] off;
    logic          last;
  } entry_t;
  state_t        state_q [NC], state_d [NC];
  logic [AW-1:0] base_q [NC], base_d [NC];
  logic [CW-1:0] idx_q [NC], idx_d [NC];
  logic [CW-1:0] end_q [NC], end_d [NC];
  logic [CW-1:0] stride_q [NC], stride_d [NC];
  logic [NC-1:0] dec_q, dec_d, cfg_ready_q, cfg_ready_d, chan_done_q, chan_done_d;
  logic [NC-1:0] abort, want, gnt;
  logic [2:0]    last_q, last_d, gnt_ch;
  logic          gnt_any, fin, dn, hold, pop;
  logic [CW-1:0] cur, stp, lim;
  logic [AW-1:0] bsel;
  logic [CW:0]   nxt;
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        wr_entry, head;
`ifdef STRIDE_READ_ENGINE_ABORT_EN
  assign abort = cfg_abort;
`else
  assign abort = '0;
`endif
  // The threshold leaves room for the grant already in flight when a channel is told to pause
  assign hold      = cnt_q >= (PW+1)'(FIFO_DEPTH - 2);
  assign pop       = req_valid & req_ready;
  assign req_valid = cnt_q != '0;
  assign head      = mem_q[rd_q];
  assign req_cu_id          = req_valid ? 8'(ENGINE_ID) : 8'h0;
  assign req_channel        = req_valid ? head.ch : 3'h0;
  assign req_base_address   = req_valid ? head.base : '0;
  assign req_address_offset = req_valid ? head.off : '0;
  assign req_last           = req_valid & head.last;
  assign cfg_ready = cfg_ready_q;
  assign chan_done = chan_done_q;
  // Round-robin grant among BUSY channels, starting after the last granted one
  always_comb begin
    gnt_any = 1'b0;
    gnt = '0;
    gnt_ch = last_q;
    for (int i = 0; i < NC; i++) want[i] = state_q[i] == S_BUSY && !abort[i];
    for (int k = 1; k <= NC; k++)
      for (int i = 0; i < NC; i++)
        if (!gnt_any && want[i] && i == (int'(last_q) + k) % NC) begin
          gnt_any = 1'b1;
          gnt[i] = 1'b1;
          gnt_ch = 3'(i);
        end
  end
  // Step the granted channel's index; an extra carry/borrow bit catches wrap so it ends the descriptor
  always_comb begin
    cur = '0;
    stp = '0;
    lim = '0;
    bsel = '0;
    dn = 1'b0;
    for (int i = 0; i < NC; i++)
      if (gnt[i]) begin
        cur = idx_q[i];
        stp = stride_q[i];
        lim = end_q[i];
        bsel = base_q[i];
        dn = dec_q[i];
      end
    nxt = dn ? {1'b0, cur} - {1'b0, stp} : {1'b0, cur} + {1'b0, stp};
    fin = stp == '0 || nxt[CW] || (dn ? nxt[CW-1:0] < lim : nxt[CW-1:0] > lim);
    wr_entry = '{ch: gnt_ch, base: bsel, off: cur, last: fin};
  end
  // Per-channel descriptor FSMs; start is loaded into the index at acceptance so SETUP only checks for an empty range
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      state_d[i] = state_q[i];
      base_d[i] = base_q[i];
      idx_d[i] = idx_q[i];
      end_d[i] = end_q[i];
      stride_d[i] = stride_q[i];
      dec_d[i] = dec_q[i];
      case (state_q[i])
        S_RESET: state_d[i] = S_IDLE;
        S_IDLE: if (cfg_valid[i]) begin
          state_d[i] = S_SETUP;
          base_d[i] = cfg_base_address[i*AW +: AW];
          idx_d[i] = cfg_start[i*CW +: CW];
          end_d[i] = cfg_end[i*CW +: CW];
          stride_d[i] = cfg_stride[i*CW +: CW];
          dec_d[i] = cfg_decrement[i];
        end
        S_SETUP: state_d[i] = (dec_q[i] ? idx_q[i] < end_q[i] : idx_q[i] > end_q[i]) ? S_DONE : S_BUSY;
        S_BUSY: begin
          idx_d[i] = gnt[i] ? nxt[CW-1:0] : idx_q[i];
          state_d[i] = gnt[i] && fin ? S_DONE : hold ? S_PAUSE : S_BUSY;
        end
        S_PAUSE: state_d[i] = hold ? S_PAUSE : S_BUSY;
        default: state_d[i] = S_IDLE;
      endcase
      if (abort[i] && (state_q[i] == S_SETUP || state_q[i] == S_BUSY || state_q[i] == S_PAUSE)) state_d[i] = S_DONE;
      cfg_ready_d[i] = state_d[i] == S_IDLE;
      chan_done_d[i] = state_d[i] == S_DONE;
    end
  end
  // Shared FIFO pointers, occupancy and arbiter memory
  always_comb begin
    cnt_d = cnt_q + (PW+1)'(gnt_any) - (PW+1)'(pop);
    wr_d = wr_q + PW'(gnt_any);
    rd_d = rd_q + PW'(pop);
    last_d = gnt_any ? gnt_ch : last_q;
  end
  // Busy while any descriptor is in flight or requests remain queued
  always_comb begin
    busy = req_valid;
    for (int i = 0; i < NC; i++) busy = busy | (state_q[i] != S_RESET && state_q[i] != S_IDLE);
  end
  // State registers; reset discards everything in flight
  always_ff @(posedge ap_clk or posedge areset)
    if (areset) begin
      for (int i = 0; i < NC; i++) begin
        state_q[i] <= S_RESET;
        base_q[i] <= '0;
        idx_q[i] <= '0;
        end_q[i] <= '0;
        stride_q[i] <= '0;
      end
      dec_q <= '0;
      cfg_ready_q <= '0;
      chan_done_q <= '0;
      last_q <= 3'(NC - 1);
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      idx_q <= idx_d;
      end_q <= end_d;
      stride_q <= stride_d;
      dec_q <= dec_d;
      cfg_ready_q <= cfg_ready_d;
      chan_done_q <= chan_done_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  // FIFO storage needs no reset; its contents are only visible while occupancy is non-zero
  always_ff @(posedge ap_clk)
    if (gnt_any) mem_q[wr_q] <= wr_entry;
endmodule

// File: tb/tb_stride_read_engine.sv
// tb_stride_read_engine: descriptor table plus hand sequences, checked against an expected-request queue
module tb_stride_read_engine;
  localparam int NC = 4, CW = 32, AW = 64, D = 16, EID = 8'h5A;
  logic ap_clk = 1'b0, areset = 1'b1;
  logic [NC-1:0] cfg_valid = '0, cfg_decrement = '0, cfg_ready, chan_done;
  logic [NC*AW-1:0] cfg_base_address = '0;
  logic [NC*CW-1:0] cfg_start = '0, cfg_end = '0, cfg_stride = '0;
  logic req_valid, req_ready = 1'b0, req_last, busy;
  logic [7:0] req_cu_id;
  logic [2:0] req_channel;
  logic [AW-1:0] req_base_address;
  logic [CW-1:0] req_address_offset;
`ifdef STRIDE_READ_ENGINE_ABORT_EN
  logic [NC-1:0] cfg_abort = '0;
`endif
  typedef struct packed {
    logic [7:0]  id;
    logic [2:0]  ch;
    logic [63:0] base;
    logic [31:0] off;
    logic        last;
  } ent_t;
  typedef struct {
    int          ch;
    bit          dec;
    logic [31:0] s, e, st;
    logic [63:0] b;
    int          n;
  } vec_t;
  ent_t exp_q[$];
  vec_t tbl[9];
  int n_vec = 0, n_bad = 0, cyc = 0, pop_cnt = 0, first_pop = -1, last_pop = 0, peak = 0, ab_next = 0;
  int done_cnt[NC];
  bit sb_on = 1'b1;

  stride_read_engine #(.ENGINE_ID(EID), .NUM_CHANNELS(NC), .COUNTER_WIDTH(CW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
    .ap_clk(ap_clk), .areset(areset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base_address(cfg_base_address), .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_stride(cfg_stride),
    .cfg_decrement(cfg_decrement),
`ifdef STRIDE_READ_ENGINE_ABORT_EN
    .cfg_abort(cfg_abort),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_cu_id(req_cu_id), .req_channel(req_channel),
    .req_base_address(req_base_address), .req_address_offset(req_address_offset), .req_last(req_last),
    .chan_done(chan_done), .busy(busy));

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc++;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Scoreboard: every accepted request must match the head of the expected queue
  always @(negedge ap_clk) begin
    if (int'(dut.cnt_q) > peak) peak = int'(dut.cnt_q);
    for (int i = 0; i < NC; i++) done_cnt[i] += int'(chan_done[i]);
    if (req_valid && req_ready) begin
      pop_cnt++;
      last_pop = cyc;
      if (first_pop < 0) first_pop = cyc;
      if (!sb_on) begin
        check("abort_offset", req_address_offset, ab_next);
        ab_next++;
      end else if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_extra: got ch %0d off %0h, expected no request", req_channel, req_address_offset);
      end else check("sb_entry", {req_cu_id, req_channel, req_base_address, req_address_offset, req_last}, exp_q.pop_front());
    end
  end

  task automatic gen(input int ch, input bit dec, input logic [31:0] s, input logic [31:0] e, input logic [31:0] st, input logic [63:0] b);
    logic [32:0] i, n;
    bit f;
    if (dec ? (s < e) : (s > e)) return;
    i = {1'b0, s};
    do begin
      n = dec ? i - {1'b0, st} : i + {1'b0, st};
      f = st == 0 || n[32] || (dec ? n[31:0] < e : n[31:0] > e);
      exp_q.push_back('{8'(EID), 3'(ch), b, i[31:0], f});
      i = n;
    end while (!f);
  endtask

  task automatic load(input int ch, input bit dec, input logic [31:0] s, input logic [31:0] e, input logic [31:0] st, input logic [63:0] b);
    cfg_start[ch*CW +: CW] = s;
    cfg_end[ch*CW +: CW] = e;
    cfg_stride[ch*CW +: CW] = st;
    cfg_base_address[ch*AW +: AW] = b;
    cfg_decrement[ch] = dec;
  endtask

  task automatic issue(input int ch, input bit dec, input logic [31:0] s, input logic [31:0] e, input logic [31:0] st, input logic [63:0] b);
    int k = 0;
    while (!cfg_ready[ch] && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL issue_timeout: ch %0d cfg_ready got 0 expected 1", ch);
    end
    load(ch, dec, s, e, st, b);
    cfg_valid[ch] = 1'b1;
    tick();
    cfg_valid[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    tick();
    while ((busy || cfg_ready != 4'hF) && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: busy got %0b expected 0", busy);
    end
  endtask

  task automatic do_reset();
    #2 areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    tick();
  endtask

  initial begin
    int p0, d0, p1;
    logic [31:0] h0;
    tbl[0] = '{0, 1'b0, 32'd0, 32'd9, 32'd3, 64'h1000, 4};
    tbl[1] = '{1, 1'b1, 32'd8, 32'd0, 32'd4, 64'h2000, 3};
    tbl[2] = '{1, 1'b1, 32'd2, 32'd5, 32'd1, 64'h2100, 0};
    tbl[3] = '{2, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd8, 64'h3000, 2};
    tbl[4] = '{3, 1'b0, 32'd5, 32'd100, 32'd0, 64'h4000, 1};
    tbl[5] = '{0, 1'b0, 32'd5, 32'd5, 32'd7, 64'h5000, 1};
    tbl[6] = '{2, 1'b1, 32'hF, 32'h0, 32'd5, 64'h6000, 4};
    tbl[7] = '{3, 1'b1, 32'd3, 32'd0, 32'hFFFF_FFFF, 64'h7000, 1};
    tbl[8] = '{0, 1'b0, 32'd10, 32'd2, 32'd1, 64'h8000, 0};
    tick();
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_busy", busy, 0);
    areset = 1'b0;
    tick();
    check("post_rst_cfg_ready", cfg_ready, 4'hF);
    // Latency and chan_done placement for ch0 0..9 step 3
    req_ready = 1'b1;
    gen(0, 1'b0, 0, 9, 3, 64'hA0);
    d0 = done_cnt[0];
    issue(0, 1'b0, 0, 9, 3, 64'hA0);
    tick();
    check("t2_req_valid", req_valid, 0);
    tick();
    check("t3_req_valid", req_valid, 1);
    tick();
    tick();
    check("done_early", chan_done[0], 0);
    tick();
    check("done_pulse", chan_done[0], 1);
    tick();
    check("done_one_cycle", chan_done[0], 0);
    wait_idle();
    check("lat_done_cnt", done_cnt[0] - d0, 1);
    check("lat_sb_left", exp_q.size(), 0);
    // Descriptor table
    foreach (tbl[v]) begin
      p0 = pop_cnt;
      d0 = done_cnt[tbl[v].ch];
      gen(tbl[v].ch, tbl[v].dec, tbl[v].s, tbl[v].e, tbl[v].st, tbl[v].b);
      issue(tbl[v].ch, tbl[v].dec, tbl[v].s, tbl[v].e, tbl[v].st, tbl[v].b);
      wait_idle();
      check($sformatf("tbl%0d_pops", v), pop_cnt - p0, tbl[v].n);
      check($sformatf("tbl%0d_done", v), done_cnt[tbl[v].ch] - d0, 1);
      check($sformatf("tbl%0d_sb_left", v), exp_q.size(), 0);
    end
    // Four channels accepted together interleave ch0..ch3 after reset
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NC; c++) exp_q.push_back('{8'(EID), 3'(c), 64'(c * 16'h100), 32'(r), r == 3});
    for (int c = 0; c < NC; c++) load(c, 1'b0, 0, 3, 1, 64'(c * 16'h100));
    p0 = pop_cnt;
    d0 = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
    first_pop = -1;
    cfg_valid = '1;
    tick();
    cfg_valid = '0;
    wait_idle();
    check("rr_pops", pop_cnt - p0, 16);
    check("rr_no_gap", last_pop - first_pop, 15);
    check("rr_done", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] - d0, 4);
    check("rr_sb_left", exp_q.size(), 0);
    // Backpressure: occupancy must cap at FIFO_DEPTH-1 and nothing is lost
    req_ready = 1'b0;
    peak = 0;
    p0 = pop_cnt;
    d0 = done_cnt[0];
    gen(0, 1'b0, 0, 99, 1, 64'hBEEF);
    issue(0, 1'b0, 0, 99, 1, 64'hBEEF);
    repeat (10) tick();
    h0 = req_address_offset;
    repeat (30) tick();
    check("bp_peak", peak, D - 1);
    check("bp_valid", req_valid, 1);
    check("bp_head", req_address_offset, 0);
    check("bp_stable", req_address_offset, h0);
    check("bp_no_pop", pop_cnt - p0, 0);
    req_ready = 1'b1;
    wait_idle();
    check("bp_pops", pop_cnt - p0, 100);
    check("bp_done", done_cnt[0] - d0, 1);
    check("bp_sb_left", exp_q.size(), 0);
    // Reset mid-descriptor with five requests queued
    req_ready = 1'b0;
    p0 = pop_cnt;
    d0 = done_cnt[0];
    issue(0, 1'b0, 0, 99, 1, 64'hDEAD);
    p1 = 0;
    while (dut.cnt_q != 5 && p1 < 50) begin
      tick();
      p1++;
    end
    check("mr_reached_5", dut.cnt_q, 5);
    #2 areset = 1'b1;
    #1;
    check("mr_req_valid", req_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_cfg_ready", cfg_ready, 0);
    check("mr_offset", req_address_offset, 0);
    tick();
    tick();
    areset = 1'b0;
    req_ready = 1'b1;
    tick();
    check("mr_cfg_ready_back", cfg_ready, 4'hF);
    check("mr_busy_after", busy, 0);
    check("mr_no_done", done_cnt[0] - d0, 0);
    check("mr_no_pop", pop_cnt - p0, 0);
    gen(0, 1'b0, 20, 24, 2, 64'hCAFE);
    issue(0, 1'b0, 20, 24, 2, 64'hCAFE);
    wait_idle();
    check("mr_new_pops", pop_cnt - p0, 3);
    check("mr_new_done", done_cnt[0] - d0, 1);
    check("mr_sb_left", exp_q.size(), 0);
`ifdef STRIDE_READ_ENGINE_ABORT_EN
    // Abort mid-run stops the channel and still reports completion; abort while idle does nothing
    sb_on = 1'b0;
    ab_next = 0;
    p0 = pop_cnt;
    d0 = done_cnt[1];
    issue(1, 1'b0, 0, 999, 1, 64'h9000);
    repeat (10) tick();
    cfg_abort[1] = 1'b1;
    tick();
    cfg_abort[1] = 1'b0;
    wait_idle();
    check("ab_done", done_cnt[1] - d0, 1);
    check("ab_stopped", (pop_cnt - p0) < 1000, 1);
    p1 = pop_cnt;
    repeat (20) tick();
    check("ab_no_more", pop_cnt, p1);
    d0 = done_cnt[2];
    cfg_abort[2] = 1'b1;
    tick();
    cfg_abort[2] = 1'b0;
    tick();
    check("ab_idle_ready", cfg_ready[2], 1);
    check("ab_idle_done", done_cnt[2] - d0, 0);
    sb_on = 1'b1;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/stride_read_engine.md
# stride_read_engine

Multi-channel, parametrised successor to the single-stream serial read engine. Each of NUM_CHANNELS independent channels accepts a descriptor (base, start, end, stride, direction) and generates one CMD_READ memory request per visited index. Channels are round-robin arbitrated into one shared request FIFO, which drains to the memory control layer over a valid/ready handshake. It sits between the engine configuration layer and the memory request arbiter of a graph cluster.

## Interface
Parameters:
- ENGINE_ID, 0, value driven on req_cu_id
- NUM_CHANNELS, 4, independent descriptor channels (1..8)
- COUNTER_WIDTH, 32, index/stride width
- ADDR_WIDTH, 64, base address width
- FIFO_DEPTH, 16, shared request FIFO entries (power of two, ≥4)

Ports:
- ap_clk  in  1  clock
- areset  in  1  reset; asynchronous, active-high
- cfg_valid  in  NUM_CHANNELS  per-channel descriptor valid
- cfg_ready  out  NUM_CHANNELS  channel idle, descriptor accepted on valid&ready
- cfg_base_address  in  NUM_CHANNELS*ADDR_WIDTH  array pointer
- cfg_start  in  NUM_CHANNELS*COUNTER_WIDTH  first index
- cfg_end  in  NUM_CHANNELS*COUNTER_WIDTH  last index, inclusive bound
- cfg_stride  in  NUM_CHANNELS*COUNTER_WIDTH  index step
- cfg_decrement  in  NUM_CHANNELS  1 = count down, 0 = count up
- req_valid  out  1  request available
- req_ready  in  1  downstream accepts
- req_cu_id  out  8  ENGINE_ID
- req_channel  out  3  originating channel
- req_base_address  out  ADDR_WIDTH  descriptor base
- req_address_offset  out  COUNTER_WIDTH  current index
- req_last  out  1  final request of its descriptor
- chan_done  out  NUM_CHANNELS  one-cycle pulse per completed descriptor
- busy  out  1  any channel non-idle or FIFO non-empty

## Operation
- Per-channel FSM: RESET → IDLE; IDLE → SETUP on cfg_valid&cfg_ready (descriptor registered); SETUP → BUSY (index ← start); BUSY → PAUSE when FIFO occupancy ≥ FIFO_DEPTH−2; PAUSE → BUSY when occupancy < FIFO_DEPTH−2; BUSY → DONE after its last write; DONE → IDLE.
- cfg_ready = 1 only in IDLE.
- Arbiter: each cycle, at most one BUSY channel writes one request. Round-robin priority starts after the last granted channel; channel 0 has priority after reset.
- Index update on grant: up: index + stride; down: index − stride. The descriptor ends when the next index passes end (up: > end; down: < end) or the add/subtract over/underflows COUNTER_WIDTH. Never wraps.
- stride = 0: exactly one request (index = start), req_last = 1.
- Empty range (up with start > end, down with start < end): zero requests; SETUP → DONE directly and chan_done pulses.
- Request fields: cu_id = ENGINE_ID, cmd CMD_READ implied, offset = current index, last = final index of descriptor.

## Timing
- Acceptance at cycle T: SETUP at T+1, first FIFO write at T+2 (if granted), earliest req_valid at T+3.
- Steady state: one request per cycle across all channels.
- FIFO output is first-word-fall-through. Payload is stable while req_valid & !req_ready. Pop on req_valid & req_ready.
- chan_done pulses the cycle after the channel's last FIFO write, independent of drain.
- FIFO never overflows: the threshold covers the one in-flight grant. A simultaneous pop and write at full-minus-one is legal.
- Reset (asserted at any time, including mid-descriptor): all FSMs → RESET, FIFO emptied, in-flight descriptors discarded with no chan_done. Outputs asynchronously 0: cfg_ready, req_valid, req_*, chan_done, busy. cfg_ready rises in the first cycle after deassertion.

## Configuration
- STRIDE_READ_ENGINE_ABORT_EN defined: adds input cfg_abort[NUM_CHANNELS]. Abort in SETUP/BUSY/PAUSE stops further writes from that channel next cycle and goes DONE (chan_done pulses). Entries already in the FIFO still drain; req_last is not forced. Abort in IDLE is ignored.
- Not defined: port absent; descriptors always run to completion.

## Test plan
- Ch0 up, start=0, end=9, stride=3, req_ready=1 -> offsets 0,3,6,9; last on 9; chan_done one cycle after the write of 9; first req_valid at T+3.
- Ch1 down, start=8, end=0, stride=4 -> offsets 8,4,0, last on 0. Then start=2, end=5 down -> zero requests, chan_done pulse.
- All 4 channels up, 0..3 stride 1, accepted same cycle -> interleaved order ch0,ch1,ch2,ch3 repeating; 16 requests with no gap.
- req_ready=0 for 40 cycles, ch0 0..99 -> occupancy peaks at FIFO_DEPTH−1, no loss or overflow. Release -> 100 requests, offsets in order.
- start=0xFFFF_FFF0, end=0xFFFF_FFFF, stride=8, up -> offsets FFFF_FFF0, FFFF_FFF8 only (overflow ends, no wrap).
- areset pulsed mid-descriptor with 5 entries queued -> req_valid=0 and busy=0 immediately; no chan_done; new descriptor after release runs cleanly. With ABORT_EN, abort mid-run -> chan_done, no further writes.
